// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write-port arbiter: FSM state encodings.
package fifo_arb_pkg;

  localparam int STATE_W = 1;

  localparam logic [STATE_W-1:0] ARB_IDLE = 1'b0;
  localparam logic [STATE_W-1:0] ARB_LOCK = 1'b1;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   gnt_onehot,
  output logic [IDX_WIDTH-1:0] gnt_idx
);

  logic                 found;
  logic [IDX_WIDTH-1:0] cand;

  // Power-of-two sizes wrap by truncation; other sizes subtract NUM_REQ explicitly.
  function automatic logic [IDX_WIDTH-1:0] rot(input logic [IDX_WIDTH-1:0] base, input int off);
    logic [IDX_WIDTH:0] sum;
    sum = {1'b0, base} + (IDX_WIDTH+1)'(off);
    if ((NUM_REQ != (1 << IDX_WIDTH)) && (sum >= (IDX_WIDTH+1)'(NUM_REQ))) begin
      sum = sum - (IDX_WIDTH+1)'(NUM_REQ);
    end
    return sum[IDX_WIDTH-1:0];
  endfunction

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rot(ptr, k);
      if (!found && req[cand]) begin
        found            = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin packet arbiter feeding a single FIFO write port through one output register.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_valid,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  // Handshake: a beat from requester i transfers in any cycle where
  // req_valid[i] && req_ready[i]; ready never depends on a registered copy of valid.

  logic [STATE_W-1:0]    state_q, state_d;
  logic [IDX_WIDTH-1:0]  owner_q, owner_d;
  logic [IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;

  logic                  can_load;
  logic                  load;
  logic [IDX_WIDTH-1:0]  sel_idx;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REQ-1:0]    pick_onehot;
  logic [IDX_WIDTH-1:0]  pick_idx;
  logic [NUM_REQ-1:0]    owner_onehot;

  function automatic logic [IDX_WIDTH-1:0] ptr_after(input logic [IDX_WIDTH-1:0] idx);
    if (NUM_REQ == (1 << IDX_WIDTH)) begin
      return idx + IDX_WIDTH'(1);
    end
    return (32'(idx) == 32'(NUM_REQ - 1)) ? '0 : idx + IDX_WIDTH'(1);
  endfunction

  rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rr_pick (
    .req        (req_valid),
    .ptr        (rr_ptr_q),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx)
  );

  assign can_load = !out_vld_q || !fifo_full;

  always_comb begin
    owner_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_WIDTH'(i)) owner_onehot[i] = 1'b1;
    end
  end

  // rstn gates arbitration so nothing is granted while the block is held in reset.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    grant     = '0;
    req_ready = '0;
    load      = 1'b0;
    sel_idx   = owner_q;
    if (rstn) begin
      case (state_q)
        ARB_IDLE: begin
          if ((|req_valid) && can_load) begin
            grant     = pick_onehot;
            req_ready = pick_onehot;
            load      = 1'b1;
            sel_idx   = pick_idx;
            if (req_last[pick_idx]) begin
              rr_ptr_d = ptr_after(pick_idx);
            end else begin
              owner_d = pick_idx;
              state_d = ARB_LOCK;
            end
          end
        end
        ARB_LOCK: begin
          grant = owner_onehot;
          if (can_load) req_ready = owner_onehot;
          if (can_load && req_valid[owner_q]) begin
            load = 1'b1;
            if (req_last[owner_q]) begin
              state_d  = ARB_IDLE;
              rr_ptr_d = ptr_after(owner_q);
            end
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IDX_WIDTH'(i)) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Load wins over drain so back-to-back beats flow without a bubble.
  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    if (load) begin
      out_vld_d = 1'b1;
      out_dat_d = sel_data;
    end else if (out_vld_q && !fifo_full) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ARB_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
    end
  end

  assign fifo_wr_valid = out_vld_q;
  assign fifo_wr_data  = out_dat_q;
  // busy is the FSM state made visible.
  assign busy          = (state_q == ARB_LOCK);

endmodule
